// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder split into STAGES carry-chained chunks with valid/ready handshaking.
// Optional macro ADDER_PIPE_SUB_EN adds a 'sub' input that adds the complement of b instead.
module adder_pipe #(
  parameter int WIDTH  = 128,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int C = WIDTH / STAGES;

  if (WIDTH < 8 || WIDTH > 1024 || STAGES < 1 || STAGES > 16 || (WIDTH % STAGES) != 0)
  begin : g_bad_cfg
    $error("adder_pipe: illegal WIDTH/STAGES combination");
  end

  logic              advance;
  logic              accept;
  logic [WIDTH-1:0]  b_eff;
  logic [STAGES-1:0] stage_valid;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance || reset;
  assign accept   = in_valid && in_ready;

`ifdef ADDER_PIPE_SUB_EN
  assign b_eff = sub ? ~b : b;
`else
  assign b_eff = b;
`endif

  // Stage k adds chunk k; unadded upper chunks ride along in the skew registers and
  // finished lower chunks accumulate in sum_q, so the last stage holds the aligned result.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = (STAGES - k) * C;

    logic [RW-1:0]        a_src;
    logic [RW-1:0]        b_src;
    logic                 c_src;
    logic                 v_src;
    logic [C:0]           total;
    logic [(k+1)*C-1:0]   sum_d;
    logic [(k+1)*C-1:0]   sum_q;
    logic                 carry_q;
    logic                 valid_q;

    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = b_eff;
      assign c_src = cin;
      assign v_src = accept;
      assign sum_d = total[C-1:0];
    end else begin : g_body
      assign a_src = g_stage[k-1].g_skew.a_q;
      assign b_src = g_stage[k-1].g_skew.b_q;
      assign c_src = g_stage[k-1].carry_q;
      assign v_src = g_stage[k-1].valid_q;
      assign sum_d = {total[C-1:0], g_stage[k-1].sum_q};
    end

    assign total = {1'b0, a_src[C-1:0]} + {1'b0, b_src[C-1:0]} + {{C{1'b0}}, c_src};

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= v_src;
        carry_q <= total[C];
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [RW-C-1:0] a_q;
      logic [RW-C-1:0] b_q;

      // Operand bits carry no state meaning on their own; the valid bit qualifies them.
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_src[RW-1:C];
          b_q <= b_src[RW-1:C];
        end
      end
    end

    assign stage_valid[k] = valid_q;
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign busy      = |stage_valid;

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe (WIDTH=128, STAGES=4): directed vectors, stall, reset flush.
// Define ADDER_PIPE_SUB_EN to also exercise the subtract path.
module tb_adder_pipe;

  localparam int W = 128;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  typedef struct {
    logic [W:0] exp;
    int         acc_cyc;
    bit         chk_lat;
  } item_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef ADDER_PIPE_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  item_t sb[$];
  item_t mon_item;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    n_expected = 0;
  int    n_received = 0;

  adder_pipe #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
`ifdef ADDER_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one transaction until accepted; the expected result is queued at acceptance.
  task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                                input logic [W:0] expv, input bit lat);
    bit acc = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        sb.push_back('{exp: expv, acc_cyc: cyc, chk_lat: lat});
        n_expected++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 64 cycles expected acceptance");
    end
  endtask

  always @(negedge clk) begin : monitor
    if (!reset && out_valid && out_ready) begin
      n_received++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got %h expected no output", {cout, sum});
      end else begin
        mon_item = sb.pop_front();
        check_output("result", {cout, sum}, mon_item.exp);
        if (mon_item.chk_lat)
          check_output("latency", (W+1)'(cyc - mon_item.acc_cyc), (W+1)'(4));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] held;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("reset_out_valid", {128'd0, out_valid}, '0);
    check_output("reset_busy", {128'd0, busy}, '0);
    check_output("reset_sum", {cout, sum}, '0);
    check_output("reset_in_ready", {128'd0, in_ready}, (W+1)'(1));
    @(posedge clk);
    #1;

    // All-ones plus carry-in ripples through every chunk boundary.
    apply_stimulus(ONES, '0, 1'b1, {1'b1, 128'd0}, 1);
    apply_stimulus(ONES, 128'd1, 1'b0, {1'b1, 128'd0}, 1);
    apply_stimulus(ONES, ONES, 1'b1, {1'b1, ONES}, 1);
    apply_stimulus(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
                   {1'b0, 128'h0000_0000_0000_0001_0000_0000_0000_0000}, 1);
    apply_stimulus(128'h8000_0000_0000_0000_0000_0000_0000_0000,
                   128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, {1'b1, 128'd0}, 1);

    for (int i = 0; i < 8; i++)
      apply_stimulus(128'(i), 128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0,
                     {1'b0, 64'd1, 64'(i)}, 1);
    repeat (8) @(posedge clk);
    #1;

    // Continuous stream with a 10-cycle consumer stall in the middle.
    fork
      begin
        for (int i = 0; i < 14; i++)
          apply_stimulus(128'(i), 128'(i), 1'b1, (W+1)'(2 * i + 1), 0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (i == 0) held = sum;
          check_output("stall_in_ready", {128'd0, in_ready}, '0);
          check_output("stall_out_valid", {128'd0, out_valid}, (W+1)'(1));
          if (i > 0) check_output("stall_sum_held", {1'b0, sum}, {1'b0, held});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Three transactions in flight, then a one-cycle reset discards them.
    for (int i = 0; i < 3; i++)
      apply_stimulus(128'(100 + i), 128'd1, 1'b0, (W+1)'(101 + i), 0);
    reset = 1'b1;
    n_expected -= sb.size();
    sb.delete();
    in_valid = 1'b1;
    a = 128'd55;
    b = 128'd66;
    @(negedge clk);
    check_output("in_ready_during_reset", {128'd0, in_ready}, (W+1)'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("post_reset_out_valid", {128'd0, out_valid}, '0);
    check_output("post_reset_busy", {128'd0, busy}, '0);
    check_output("post_reset_in_ready", {128'd0, in_ready}, (W+1)'(1));
    repeat (10) @(posedge clk);
    #1;
    check_output("flushed_busy", {128'd0, busy}, '0);

`ifdef ADDER_PIPE_SUB_EN
    sub = 1'b1;
    apply_stimulus(128'd5, 128'd7, 1'b1, {1'b0, ONES - 128'd1}, 1);
    apply_stimulus(128'd7, 128'd5, 1'b1, {1'b1, 128'd2}, 1);
    sub = 1'b0;
`endif

    apply_stimulus(128'd40, 128'd2, 1'b0, (W+1)'(42), 1);

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_empty", (W+1)'(sb.size()), '0);
    check_output("result_count", (W+1)'(n_received), (W+1)'(n_expected));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
- REQ-001 SHALL have parameter WIDTH, default 128: operand/sum width in bits; legal range 8 to 1024.
- REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; legal range 1 to 16; WIDTH SHALL be divisible by STAGES, and elaboration SHALL fail otherwise.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 SHALL have port in_valid, input, 1 bit: operands present.
- REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
- REQ-007 SHALL have ports a and b, input, WIDTH bits each: operands.
- REQ-008 SHALL have port cin, input, 1 bit: carry in.
- REQ-009 SHALL have port out_valid, output, 1 bit: result present.
- REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
- REQ-011 SHALL have port sum, output, WIDTH bits: result.
- REQ-012 SHALL have port cout, output, 1 bit: carry out.
- REQ-013 SHALL have port busy, output, 1 bit: OR of all stage valid bits.

Function
- REQ-014 SHALL split the operands into STAGES chunks of C = WIDTH/STAGES bits; stage k adds chunk k (LSB chunk first) plus the carry registered by stage k-1; stage 0 uses cin.
- REQ-015 SHALL carry not-yet-added upper chunks forward in skew registers and completed lower sum chunks forward in deskew registers, so that each transaction emerges with all WIDTH sum bits aligned.
- REQ-016 SHALL produce the result {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1), exactly.
- REQ-017 SHALL accept a transaction on a cycle when in_valid && in_ready are both high.
- REQ-018 SHALL transfer a transaction out on a cycle when out_valid && out_ready are both high.
- REQ-019 SHALL define advance = !out_valid || out_ready; all stages shift together when advance = 1 and all hold when advance = 0.
- REQ-020 SHALL drive in_ready = advance combinationally, with no other dependency on in_valid.
- REQ-021 SHALL raise out_valid exactly STAGES cycles after acceptance when no stall occurs, giving a latency of STAGES and a throughput of 1 result per cycle.
- REQ-022 SHALL advance bubbles (stage valid = 0) like data; a bubble never raises out_valid.
- REQ-023 SHALL hold sum and cout stable while out_valid = 1 and out_ready = 0.
- REQ-024 SHALL deliver results in acceptance order, with none dropped or duplicated.
- REQ-025 SHALL, when a transfer-out and an accept occur in the same cycle, perform both.
- REQ-026 SHALL let an all-ones operand carry propagate across every chunk boundary correctly.

Reset
- REQ-027 SHALL, on reset = 1 at a clock edge, clear all stage valid bits and drive out_valid = 0, busy = 0, sum = 0, cout = 0; in-flight transactions are discarded.
- REQ-028 SHALL hold in_ready = 1 while reset is high and on the first cycle after reset.
- REQ-029 SHALL ignore in_valid during a cycle in which reset = 1.

Configuration
- REQ-030 SHALL, with macro ADDER_PIPE_SUB_EN defined, add a 1-bit input port sub, sampled with the operands; when sub = 1 the result SHALL be {cout, sum} = a + ~b + cin (cin = 1 gives a - b, with cout = 1 meaning no borrow).
- REQ-031 SHALL, without ADDER_PIPE_SUB_EN, not have the sub port and perform addition only.

Verification (WIDTH = 128, STAGES = 4)
- REQ-032 Bench SHALL drive a = 2^128-1, b = 0, cin = 1 with out_ready = 1 -> sum = 0, cout = 1, out_valid high exactly 4 cycles after acceptance.
- REQ-033 Bench SHALL send 8 back-to-back vectors a = i, b = 2^64, cin = 0 (i = 0..7) with out_ready = 1 -> results 2^64 + i on 8 consecutive cycles, in order.
- REQ-034 Bench SHALL stream continuously, hold out_ready = 0 for 10 cycles, then release -> in_ready = 0 while stalled, sum held stable, no result lost or duplicated after release.
- REQ-035 Bench SHALL assert reset for 1 cycle with 3 transactions in flight -> out_valid = 0, busy = 0 next cycle, and no stale result ever emerges.
- REQ-036 Bench SHALL, with ADDER_PIPE_SUB_EN, drive sub = 1, a = 5, b = 7, cin = 1 -> sum = 2^128-2, cout = 0; and a = 7, b = 5 -> sum = 2, cout = 1.
